// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the single-cycle RISC-V core.
// Takes a host byte stream (16-bit word count N, LSB first, then N
// little-endian 32-bit words) and writes the words into instruction memory
// from word address 0. The core is held in reset until the image is complete.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN appends one XOR checksum
// byte to the stream (XOR of every byte since reset) that must match before
// the core is released.
module prog_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_run,
    output logic                  done,
    output logic                  error
);

    // Largest legal word count: the whole instruction memory.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WCNT_ONE = 1;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        RUN,
        ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t                state;
    logic [15:0]           len;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_p0;   // bytes 0..2 of the word being assembled
    logic [ADDR_WIDTH:0]   wcnt;      // next word address, one spare bit
    logic                  accept;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign accept = in_valid && in_ready;

    // True when the word at index idx is the final word of an N-word image.
    function automatic logic last_word(input logic [ADDR_WIDTH:0] idx,
                                       input logic [15:0]         n);
        return (17'(idx) + 17'd1) == {1'b0, n};
    endfunction

    // Load sequencer: stream parsing, word assembly, memory write strobe and
    // core release, all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LEN_LO;
            len        <= '0;
            byte_cnt   <= '0;
            word_p0    <= '0;
            wcnt       <= '0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_run   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (accept && state != CHK) begin
                csum <= csum ^ in_data;
            end
`endif
            case (state)
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        if ({1'b0, in_data, len[7:0]} > MAX_WORDS) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if ({in_data, len[7:0]} == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state    <= CHK;
`else
                            // Empty image: nothing to write, release at once.
                            state    <= RUN;
                            core_run <= 1'b1;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    word_p0[7:0]   <= in_data;
                            2'd1:    word_p0[15:8]  <= in_data;
                            2'd2:    word_p0[23:16] <= in_data;
                            default: ;
                        endcase
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wcnt[ADDR_WIDTH-1:0];
                            imem_wdata <= {in_data, word_p0};
                            wcnt       <= wcnt + WCNT_ONE;
                            if (last_word(wcnt, len)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state    <= CHK;
`else
                                // Release waits one cycle in RUN so the
                                // final write lands before the core starts.
                                state    <= RUN;
                                in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state    <= RUN;
                            core_run <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                RUN: begin
                    in_ready <= 1'b0;
                    core_run <= 1'b1;
                    done     <= 1'b1;
                end
                ERR: begin
                    in_ready <= 1'b0;
                end
                default: begin
                    state    <= ERR;
                    error    <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Builds byte-stream
// images, predicts the memory writes and the release/error outcome from the
// stream format, and compares against what the loader does.
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int AW = 10;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_run;
    logic          done;
    logic          error;

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Stream under test and what happened to each byte.
    logic [7:0]    stream[$];
    logic          acc_q[$];
    longint        acc_t[$];
    // Observed writes.
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    longint        wt_q[$];
    // Predicted writes and the index of the byte that completes each word.
    logic [AW-1:0] ea_q[$];
    logic [31:0]   ed_q[$];
    int            etrig_q[$];

    longint run_rise_t = -1;
    longint err_rise_t = -1;
    logic   run_prev = 1'b0;
    logic   err_prev = 1'b0;

    // Monitor: sample outputs on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            wt_q.push_back($time);
        end
        if (core_run && !run_prev) run_rise_t = $time;
        if (error && !err_prev) err_rise_t = $time;
        run_prev = core_run;
        err_prev = error;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Every task is entered and left 1 ns after a rising edge.
    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic   r;
        longint t;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        r = in_ready;
        @(posedge clk);
        t = $time;
        #1;
        in_valid = 1'b0;
        acc_q.push_back(r);
        acc_t.push_back(t);
    endtask

    task automatic build_stream(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic bad, input int extra);
        logic [31:0] w;
        logic [7:0]  c;
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        if (32'(n) <= (32'd1 << AW)) begin
            for (int i = 0; i < int'(n); i++) begin
                w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom;
                for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
            end
            if (CHK_EN) begin
                c = 8'h00;
                foreach (stream[i]) c = c ^ stream[i];
                if (bad) c = ~c;
                stream.push_back(c);
            end
        end
        for (int i = 0; i < extra; i++) stream.push_back(8'($urandom));
    endtask

    // Reference: interpret the stream by its format rules.
    task automatic model(output int n_acc, output logic m_run, output logic m_err,
                         output int term, output int dly);
        int         n;
        int         ci;
        logic [7:0] c;
        n = int'({stream[1], stream[0]});
        ea_q.delete();
        ed_q.delete();
        etrig_q.delete();
        m_run = 1'b0;
        m_err = 1'b0;
        if (n > (1 << AW)) begin
            m_err = 1'b1; term = 1; dly = 5; n_acc = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                int b;
                b = 2 + 4 * i;
                ea_q.push_back(AW'(i));
                ed_q.push_back({stream[b+3], stream[b+2], stream[b+1], stream[b]});
                etrig_q.push_back(b + 3);
            end
            ci = 2 + 4 * n;
            if (CHK_EN) begin
                c = 8'h00;
                for (int i = 0; i < ci; i++) c = c ^ stream[i];
                m_run = (stream[ci] == c);
                m_err = !m_run;
                term = ci; dly = 5; n_acc = ci + 1;
            end else begin
                m_run = 1'b1;
                n_acc = ci;
                if (n == 0) begin term = 1; dly = 5; end
                else begin term = ci - 1; dly = 15; end
            end
        end
    endtask

    task automatic run_image(input string nm, input logic [15:0] n, input logic [31:0] w0,
                             input logic [31:0] w1, input int gap, input int extra, input logic bad,
                             input logic exp_run, input logic exp_err, input int exp_wr);
        int   n_acc, term, dly, wbase, nbad, nw;
        logic m_run, m_err;
        do_reset();
        build_stream(n, w0, w1, bad, extra);
        model(n_acc, m_run, m_err, term, dly);
        acc_q.delete();
        acc_t.delete();
        wbase = wd_q.size();
        foreach (stream[i]) send_byte(stream[i], (gap > 0) ? int'($urandom_range(0, gap)) : 0);
        repeat (6) begin @(posedge clk); #1; end
        nbad = 0;
        foreach (acc_q[i]) if (acc_q[i] !== (i < n_acc)) nbad++;
        check({nm, "_accept_errs"}, 64'(nbad), 64'd0);
        nw = wd_q.size() - wbase;
        check({nm, "_nwrites"}, 64'(nw), 64'(exp_wr));
        for (int i = 0; i < ed_q.size() && i < nw; i++) begin
            check($sformatf("%s_addr%0d", nm, i), 64'(wa_q[wbase+i]), 64'(ea_q[i]));
            check($sformatf("%s_data%0d", nm, i), 64'(wd_q[wbase+i]), 64'(ed_q[i]));
            check($sformatf("%s_wtime%0d", nm, i), 64'(wt_q[wbase+i]), 64'(acc_t[etrig_q[i]] + 5));
        end
        check({nm, "_core_run"}, 64'(core_run), 64'(exp_run));
        check({nm, "_done"}, 64'(done), 64'(exp_run));
        check({nm, "_error"}, 64'(error), 64'(exp_err));
        check({nm, "_in_ready"}, 64'(in_ready), 64'd0);
        if (m_run) check({nm, "_run_time"}, 64'(run_rise_t), 64'(acc_t[term] + dly));
        if (m_err) check({nm, "_err_time"}, 64'(err_rise_t), 64'(acc_t[term] + dly));
    endtask

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        int          extra;
        logic        bad;
        logic        exp_run;
        logic        exp_err;
        int          exp_wr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int wbase;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        @(posedge clk); #1;

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_core_run", 64'(core_run), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);

        tbl[0] = '{16'd2,      32'h00000013, 32'h005000B3, 0, 0, 1'b0, 1'b1, 1'b0, 2};
        tbl[1] = '{16'd2,      32'h00000013, 32'h005000B3, 5, 0, 1'b0, 1'b1, 1'b0, 2};
        tbl[2] = '{16'h0401,   32'h0,        32'h0,        0, 3, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{16'd0,      32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 0};
        tbl[4] = '{16'd2,      32'h00000013, 32'h005000B3, 0, 4, 1'b0, 1'b1, 1'b0, 2};
        tbl[5] = '{16'd1,      32'h04030201, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 1};
        tbl[6] = '{16'd5,      32'hDEADBEEF, 32'h12345678, 2, 1, 1'b0, 1'b1, 1'b0, 5};
        tbl[7] = '{16'h0400,   32'hCAFEF00D, 32'h0BADC0DE, 0, 0, 1'b0, 1'b1, 1'b0, 1024};
        tbl[8] = '{16'hFFFF,   32'h0,        32'h0,        0, 2, 1'b0, 1'b0, 1'b1, 0};
        tbl[9] = '{16'd1,      32'h04030201, 32'h0,        0, 0, 1'b1, !CHK_EN, CHK_EN, 1};

        for (int v = 0; v < 10; v++) begin
            run_image($sformatf("vec%0d", v), tbl[v].n, tbl[v].w0, tbl[v].w1, tbl[v].gap,
                      tbl[v].extra, tbl[v].bad, tbl[v].exp_run, tbl[v].exp_err, tbl[v].exp_wr);
        end

        // Random images with random idle gaps between bytes.
        for (int r = 0; r < 4; r++) begin
            int rn;
            rn = int'($urandom_range(1, 8));
            run_image($sformatf("rand%0d", r), 16'(rn), $urandom, $urandom,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b0, rn);
        end

        // Reset after 6 of 8 payload bytes: second word must never be written.
        do_reset();
        build_stream(16'd2, 32'h00000013, 32'h005000B3, 1'b0, 0);
        acc_q.delete();
        acc_t.delete();
        wbase = wd_q.size();
        for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("midrst_imem_addr", 64'(imem_addr), 64'd0);
        check("midrst_core_run", 64'(core_run), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("midrst_nwrites", 64'(wd_q.size() - wbase), 64'd1);
        if (wd_q.size() > wbase) check("midrst_word0", 64'(wd_q[wbase]), 64'h00000013);

        run_image("reload", 16'd2, 32'h00000013, 32'h005000B3, 0, 0, 1'b0, 1'b1, 1'b0, 2);

        // Reset while running: core_run must drop without waiting for a clock.
        #3;
        rst = 1'b0;
        #1;
        check("async_core_run", 64'(core_run), 64'd0);
        check("async_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("async_in_ready", 64'(in_ready), 64'd1);
        check("async_error", 64'(error), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
